axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3-style burst responder (slave) backed by an on-chip single-port SRAM.
- It is the memory-side counterpart of the cache AXI bridge and answers its INCR line fills and write-backs.
- Used as the main-memory model in SoC simulation and as a small on-chip RAM in FPGA builds.
- One transaction is in flight at a time; writes take priority over reads.

Parameters:
- WORD_AW, 14, word-address width; memory is 2^WORD_AW 32-bit words (64 KiB default).
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- awid  in  ID_W  write ID
- awaddr  in  32  write byte address
- awlen  in  8  beats-1
- awsize  in  3  must be 3'b010
- awburst  in  2  burst type
- awvalid  in  1  / awready  out  1  AW handshake
- wid  in  ID_W  ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  last write beat
- wvalid  in  1  / wready  out  1  W handshake
- bid  out  ID_W  = captured awid
- bresp  out  2  write response
- bvalid  out  1  / bready  in  1  B handshake
- arid  in  ID_W  read ID
- araddr  in  32  read byte address
- arlen  in  8  beats-1
- arsize  in  3  must be 3'b010
- arburst  in  2  burst type
- arvalid  in  1  / arready  out  1  AR handshake
- rid  out  ID_W  = captured arid
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  / rready  in  1  R handshake

Behaviour:
- Reset: clk and reset are resetn, synchronous, active-low. State goes to IDLE. All outputs are 0: awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata. SRAM contents are not cleared.
- Reset mid-burst: the transaction is abandoned with no B or R response. Beats already written stay written.
- States: IDLE, WR, WRESP, RADDR, RDATA.
- IDLE, ready signals: awready=1. arready = !awvalid, so a write presented in the same cycle as a read wins.
- IDLE, AW accepted: capture awid, word address = awaddr[WORD_AW+1:2], awlen, awburst. Clear the beat counter and error flags. Go to WR.
- IDLE, AR accepted: capture the same fields from the AR channel. Go to RADDR.
- WR: wready=1. On each wvalid beat, write SRAM with byte enables from wstrb, then advance the address (+1 for INCR, hold for FIXED) and increment the counter.
- WR, last beat: the burst ends on beat number awlen+1 whatever wlast says, then go to WRESP.
- WR, wlast check: wlast must be high on the final beat and low on every other beat. Any mismatch sets a SLVERR flag.
- WRESP: bvalid=1, held until bready. Then go to IDLE.
- RADDR (1 cycle): drive the SRAM read address, go to RDATA.
- RDATA: rvalid=1, rdata = SRAM output registered, rlast = (counter==len). Hold all values while !rready.
- RDATA, beat accepted: if last, go to IDLE. Otherwise advance address and counter and go to RADDR.
- Read throughput is 1 beat per 2 cycles. Latency from AR handshake to first rvalid is 2 cycles.
- Response codes, priority highest first:
  - DECERR 2'b11: any beat address outside memory (byte addr >= 4*2^WORD_AW). Writes to such beats are dropped; reads of them return 0.
  - SLVERR 2'b10: size != 3'b010, burst == WRAP or reserved, or a wlast mismatch. Data is still handled as INCR.
  - OKAY 2'b00: otherwise.
  - rresp is evaluated per beat; bresp is sticky over the whole burst.
- Address increment wraps modulo 2^32 at the byte level. The word index is then re-checked against the memory range.
- araddr/awaddr[1:0] are ignored (accesses are word-aligned).

Decomposition:
- Shared package axi_pkg:
  - resp codes OKAY/EXOKAY/SLVERR/DECERR
  - burst codes FIXED/INCR/WRAP
  - SIZE_4B
- Shared with the bridge: ID_W and the data-width constant.
- One sub-module, sram_sp_bw:
  - single-port, byte-write, synchronous read (1-cycle)
  - depth 2^WORD_AW
  - optional $readmemh init under a simulation define

Test Plan:
- Write burst, then read: AW addr 0x100 len 3 INCR, W beats 0xA0..0xA3 strb 4'hF with wlast on beat 4 -> bresp OKAY, bid=awid. AR 0x100 len 3 -> rdata A0,A1,A2,A3; rlast only on beat 4; rresp OKAY.
- Byte strobe: preload word 0x200 = 0x11223344; single-beat write 0xAABBCCDD strb 4'b0101 -> read returns 0x11BB33DD.
- Backpressure: rready low for 3 cycles mid-burst and bready low for 5 cycles -> rdata/rlast/bvalid stable; no beat lost or duplicated.
- Simultaneous requests: awvalid and arvalid asserted in the same cycle -> awready=1, arready=0. The read is accepted only after the B handshake and returns the new data.
- Errors:
  - wlast asserted on beat 2 of a len-3 burst -> 4 beats still consumed, bresp SLVERR.
  - AR at byte address 4*2^WORD_AW -> rresp DECERR, rdata 0.
- Reset: resetn low during beat 2 of a read burst -> next cycle rvalid=0 and state IDLE; a subsequent AR is served normally.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI3 encodings and widths shared by the SRAM slave and the cache AXI bridge.
package axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    // Decode errors outrank slave errors.
    function automatic logic [1:0] resp_encode(input logic dec, input logic slv);
        if (dec) begin
            return RESP_DECERR;
        end else if (slv) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    function automatic logic hdr_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/sram_sp_bw.sv
// Single-port SRAM with per-byte write enables and a one-cycle registered read.
module sram_sp_bw #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic            i_re,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    output logic [DW-1:0]   o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;

    // Byte-masked write and read-enable-gated output register.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 burst slave over a single-port SRAM: one transaction at a time, writes first.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int WORD_AW = 14,
    parameter int ID_W    = AXI_ID_W
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RADDR = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    logic [2:0]      r_state, w_state_nxt;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_addr;
    logic [7:0]      r_len, r_cnt;
    logic            r_fixed, r_slv, r_dec, r_rdec;
    logic            r_awready, r_wready, r_bvalid, r_rvalid, r_rlast;
    logic [1:0]      r_bresp, r_rresp;
    logic [31:0]     w_sram_q;
    logic            w_aw_hs, w_ar_hs, w_w_hs, w_last_beat, w_beat_dec, w_wlast_err;
    logic            w_unused_ok;

    assign w_aw_hs     = (r_state == ST_IDLE) && r_awready && awvalid;
    assign w_ar_hs     = (r_state == ST_IDLE) && r_awready && !awvalid && arvalid;
    assign w_w_hs      = r_wready && wvalid;
    assign w_last_beat = (r_cnt == r_len);
    assign w_wlast_err = (wlast != w_last_beat);
    // Any set bit above the memory's byte range means the beat falls off the end of RAM.
    assign w_beat_dec  = |r_addr[31:WORD_AW+2];
    assign w_unused_ok = ^{wid, awaddr[1:0], araddr[1:0]};

    // Next-state decode for the single outstanding transaction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    w_state_nxt = ST_WR;
                end else if (w_ar_hs) begin
                    w_state_nxt = ST_RADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                if (w_w_hs && w_last_beat) begin
                    w_state_nxt = ST_WRESP;
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_WRESP: begin
                if (bready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_RADDR: w_state_nxt = ST_RDATA;
            ST_RDATA: begin
                if (rready && r_rlast) begin
                    w_state_nxt = ST_IDLE;
                end else if (rready) begin
                    w_state_nxt = ST_RADDR;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, captured request fields and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_addr    <= 32'h0;
            r_len     <= 8'h0;
            r_cnt     <= 8'h0;
            r_fixed   <= 1'b0;
            r_slv     <= 1'b0;
            r_dec     <= 1'b0;
            r_rdec    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_state   <= w_state_nxt;
            r_awready <= (w_state_nxt == ST_IDLE);
            r_wready  <= (w_state_nxt == ST_WR);
            r_bvalid  <= (w_state_nxt == ST_WRESP);
            r_rvalid  <= (w_state_nxt == ST_RDATA);
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_id    <= awid;
                        r_addr  <= {awaddr[31:2], 2'b00};
                        r_len   <= awlen;
                        r_fixed <= (awburst == BURST_FIXED);
                        r_slv   <= hdr_err(awsize, awburst);
                        r_dec   <= 1'b0;
                        r_cnt   <= 8'h0;
                    end else if (w_ar_hs) begin
                        r_id    <= arid;
                        r_addr  <= {araddr[31:2], 2'b00};
                        r_len   <= arlen;
                        r_fixed <= (arburst == BURST_FIXED);
                        r_slv   <= hdr_err(arsize, arburst);
                        r_cnt   <= 8'h0;
                    end
                end
                ST_WR: begin
                    if (w_w_hs) begin
                        r_cnt <= r_cnt + 8'd1;
                        r_dec <= r_dec | w_beat_dec;
                        r_slv <= r_slv | w_wlast_err;
                        if (!r_fixed) begin
                            r_addr <= r_addr + 32'd4;
                        end
                        if (w_last_beat) begin
                            r_bresp <= resp_encode(r_dec | w_beat_dec, r_slv | w_wlast_err);
                        end
                    end
                end
                ST_RADDR: begin
                    r_rdec  <= w_beat_dec;
                    r_rlast <= w_last_beat;
                    r_rresp <= resp_encode(w_beat_dec, r_slv);
                end
                ST_RDATA: begin
                    if (rready && r_rlast) begin
                        r_rlast <= 1'b0;
                        r_rresp <= RESP_OKAY;
                    end else if (rready) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (!r_fixed) begin
                            r_addr <= r_addr + 32'd4;
                        end
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    sram_sp_bw #(
        .AW (WORD_AW),
        .DW (AXI_DATA_W)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_w_hs && !w_beat_dec),
        .i_re    (r_state == ST_RADDR),
        .i_addr  (r_addr[WORD_AW+1:2]),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .o_rdata (w_sram_q)
    );

    assign awready = r_awready;
    assign arready = r_awready && !awvalid;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign bid     = r_id;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rresp   = r_rresp;
    assign rid     = r_id;
    // Out-of-range beats and idle cycles present zero data.
    assign rdata   = (r_rvalid && !r_rdec) ? w_sram_q : 32'h0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave against a word-addressed memory model.
module tb_axi_sram_slave;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [int];
    logic [31:0] wq [256];
    logic [3:0]  sq [256];
    logic [31:0] rd_q [256];
    logic [1:0]  rr_q [256];
    logic        rl_q [256];
    logic [1:0]  got_bresp;
    logic [3:0]  got_bid, got_rid;
    logic        stall_ok, r_extra;
    int          got_lat;
    time         t_ar, t_b;

    axi_sram_slave #(.WORD_AW(14), .ID_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (byte-address arithmetic) ----------------
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i, input logic [1:0] burst);
        logic [31:0] b;
        b = {base[31:2], 2'b00};
        if (burst == 2'b00) return b;
        return b + 32'(4 * i);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'h0001_0000;
    endfunction

    function automatic bit hdr_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || (burst == 2'b10) || (burst == 2'b11);
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] base, input int len,
                                               input logic [1:0] burst, input logic [2:0] size, input int wl);
        bit dec;
        logic [31:0] a, w;
        dec = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(base, i, burst);
            if (!in_range(a)) begin
                dec = 1'b1;
            end else begin
                w = mdl.exists(int'(a[31:2])) ? mdl[int'(a[31:2])] : 32'h0;
                for (int b = 0; b < 4; b++) if (sq[i][b]) w[8*b +: 8] = wq[i][8*b +: 8];
                mdl[int'(a[31:2])] = w;
            end
        end
        if (dec) return 2'b11;
        if (hdr_bad(size, burst) || wl != len) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] base, input int i, input logic [1:0] burst);
        logic [31:0] a;
        a = beat_addr(base, i, burst);
        if (!in_range(a) || !mdl.exists(int'(a[31:2]))) return 32'h0;
        return mdl[int'(a[31:2])];
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] base, input int i,
                                             input logic [1:0] burst, input logic [2:0] size);
        if (!in_range(beat_addr(base, i, burst))) return 2'b11;
        if (hdr_bad(size, burst)) return 2'b10;
        return 2'b00;
    endfunction

    // ---------------- bus drivers ----------------
    function automatic logic sig_of(input int sel);
        case (sel)
            0: return awready;
            1: return wready;
            2: return bvalid;
            3: return arready;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig_of(sel) && n < TMO);
        if (!sig_of(sel)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no handshake after %0d cycles, required within %0d", nm, n, TMO);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awvalid = 1'b1;
        wait_sig(0, "aw", n);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input int len, input int wl);
        int n;
        for (int i = 0; i <= len; i++) begin
            wdata = wq[i]; wstrb = sq[i]; wlast = (i == wl); wvalid = 1'b1;
            wait_sig(1, "w", n);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic do_b(input int stall_n);
        int n;
        logic [1:0] p0;
        wait_sig(2, "b", n);
        stall_ok = 1'b1;
        p0 = bresp;
        repeat (stall_n) begin
            @(negedge clk);
            if (!bvalid || bresp !== p0) stall_ok = 1'b0;
        end
        got_bresp = bresp;
        got_bid = bid;
        bready = 1'b1;
        t_b = $time;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arsize = size; arvalid = 1'b1;
        wait_sig(3, "ar", n);
        t_ar = $time;
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_r(input int len, input int stall_beat, input int stall_n);
        int n;
        logic [31:0] d0;
        logic [1:0] p0;
        logic l0;
        stall_ok = 1'b1;
        for (int i = 0; i <= len; i++) begin
            wait_sig(4, "r", n);
            if (i == 0) got_lat = n;
            if (i == stall_beat) begin
                d0 = rdata; p0 = rresp; l0 = rlast;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (!rvalid || rdata !== d0 || rresp !== p0 || rlast !== l0) stall_ok = 1'b0;
                end
            end
            rd_q[i] = rdata; rr_q[i] = rresp; rl_q[i] = rlast; got_rid = rid;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
        @(negedge clk);
        r_extra = rvalid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bresp, rresp, bid, rid, rdata} !== 44'h0) begin
            errors++;
            $display("FAIL reset_data: got bresp=%h rresp=%h bid=%h rid=%h rdata=%h required all 0",
                     bresp, rresp, bid, rid, rdata);
        end
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got awready=%b arready=%b required 1 1", awready, arready);
        end
    endtask

    task automatic test_write_read;
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            wq[i] = 32'hA0 + 32'(i);
            sq[i] = 4'hF;
        end
        exp = model_write(32'h100, 3, 2'b01, 3'b010, 3);
        do_aw(4'h5, 32'h100, 3, 2'b01, 3'b010);
        do_w(3, 3);
        do_b(0);
        checks++;
        if (got_bresp !== exp || got_bid !== 4'h5) begin
            errors++;
            $display("FAIL wr_bresp: got resp=%h id=%h required resp=%h id=5", got_bresp, got_bid, exp);
        end
        do_ar(4'h9, 32'h100, 3, 2'b01, 3'b010);
        do_r(3, -1, 0);
        checks++;
        if (got_lat !== 2 || got_rid !== 4'h9) begin
            errors++;
            $display("FAIL rd_lat_id: got lat=%0d rid=%h required lat=2 rid=9", got_lat, got_rid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q[i] !== 32'hA0 + 32'(i) || rr_q[i] !== 2'b00 || rl_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL rd_beat%0d: got data=%h resp=%h last=%b required data=%h resp=0 last=%b",
                         i, rd_q[i], rr_q[i], rl_q[i], 32'hA0 + 32'(i), (i == 3));
            end
        end
        checks++;
        if (r_extra !== 1'b0) begin
            errors++;
            $display("FAIL rd_extra: got rvalid=%b after last beat required 0", r_extra);
        end
    endtask

    task automatic test_byte_strobe;
        logic [1:0] exp;
        wq[0] = 32'h1122_3344; sq[0] = 4'hF;
        exp = model_write(32'h200, 0, 2'b01, 3'b010, 0);
        do_aw(4'h1, 32'h200, 0, 2'b01, 3'b010);
        do_w(0, 0);
        do_b(0);
        wq[0] = 32'hAABB_CCDD; sq[0] = 4'b0101;
        exp = model_write(32'h200, 0, 2'b01, 3'b010, 0);
        do_aw(4'h1, 32'h200, 0, 2'b01, 3'b010);
        do_w(0, 0);
        do_b(0);
        checks++;
        if (got_bresp !== exp) begin
            errors++;
            $display("FAIL strb_bresp: got %h required %h", got_bresp, exp);
        end
        do_ar(4'h1, 32'h200, 0, 2'b01, 3'b010);
        do_r(0, -1, 0);
        checks++;
        if (rd_q[0] !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strb_data: got %h required 11bb33dd", rd_q[0]);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            wq[i] = $urandom;
            sq[i] = 4'hF;
        end
        exp = model_write(32'h300, 3, 2'b01, 3'b010, 3);
        do_aw(4'h7, 32'h300, 3, 2'b01, 3'b010);
        do_w(3, 3);
        do_b(5);
        checks++;
        if (stall_ok !== 1'b1 || got_bresp !== exp) begin
            errors++;
            $display("FAIL b_stall: got stable=%b resp=%h required stable=1 resp=%h", stall_ok, got_bresp, exp);
        end
        do_ar(4'h7, 32'h300, 3, 2'b01, 3'b010);
        do_r(3, 1, 3);
        checks++;
        if (stall_ok !== 1'b1) begin
            errors++;
            $display("FAIL r_stall: got stable=%b required 1", stall_ok);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q[i] !== exp_rdata(32'h300, i, 2'b01) || rl_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%b required data=%h last=%b",
                         i, rd_q[i], rl_q[i], exp_rdata(32'h300, i, 2'b01), (i == 3));
            end
        end
    endtask

    task automatic test_simultaneous;
        int n;
        logic ok;
        wq[0] = $urandom; sq[0] = 4'hF;
        void'(model_write(32'h400, 0, 2'b01, 3'b010, 0));
        @(posedge clk); #1;
        awid = 4'h2; awaddr = 32'h400; awlen = 8'h0; awburst = 2'b01; awsize = 3'b010; awvalid = 1'b1;
        arid = 4'h3; araddr = 32'h400; arlen = 8'h0; arburst = 2'b01; arsize = 3'b010; arvalid = 1'b1;
        @(negedge clk);
        ok = awready && !arready;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL simul_ready: got awready=%b arready=%b required 1 0", awready, arready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        do_w(0, 0);
        do_b(0);
        wait_sig(3, "ar_simul", n);
        t_ar = $time;
        @(posedge clk); #1;
        arvalid = 1'b0;
        do_r(0, -1, 0);
        checks++;
        if (!(t_ar > t_b) || rd_q[0] !== wq[0] || got_rid !== 4'h3) begin
            errors++;
            $display("FAIL simul_order: got t_ar=%0t t_b=%0t data=%h rid=%h required t_ar>t_b data=%h rid=3",
                     t_ar, t_b, rd_q[0], got_rid, wq[0]);
        end
    endtask

    task automatic test_errors;
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            wq[i] = $urandom;
            sq[i] = 4'hF;
        end
        exp = model_write(32'h500, 3, 2'b01, 3'b010, 1);
        do_aw(4'h4, 32'h500, 3, 2'b01, 3'b010);
        do_w(3, 1);
        do_b(0);
        checks++;
        if (got_bresp !== exp || exp !== 2'b10) begin
            errors++;
            $display("FAIL wlast_err: got %h required 2", got_bresp);
        end
        do_ar(4'h4, 32'h500, 3, 2'b01, 3'b010);
        do_r(3, -1, 0);
        checks++;
        if (rd_q[3] !== wq[3] || rd_q[1] !== wq[1]) begin
            errors++;
            $display("FAIL wlast_beats: got b1=%h b3=%h required b1=%h b3=%h", rd_q[1], rd_q[3], wq[1], wq[3]);
        end
        do_ar(4'h6, 32'h0001_0000, 0, 2'b01, 3'b010);
        do_r(0, -1, 0);
        checks++;
        if (rr_q[0] !== 2'b11 || rd_q[0] !== 32'h0) begin
            errors++;
            $display("FAIL decerr_rd: got resp=%h data=%h required resp=3 data=0", rr_q[0], rd_q[0]);
        end
        do_ar(4'h6, 32'h500, 0, 2'b01, 3'b011);
        do_r(0, -1, 0);
        checks++;
        if (rr_q[0] !== 2'b10) begin
            errors++;
            $display("FAIL size_err: got resp=%h required 2", rr_q[0]);
        end
        // A two-beat burst wrapping from the top of the address space back to word 0.
        wq[0] = $urandom; wq[1] = $urandom; sq[0] = 4'hF; sq[1] = 4'hF;
        exp = model_write(32'hFFFF_FFFC, 1, 2'b01, 3'b010, 1);
        do_aw(4'h8, 32'hFFFF_FFFC, 1, 2'b01, 3'b010);
        do_w(1, 1);
        do_b(0);
        checks++;
        if (got_bresp !== exp) begin
            errors++;
            $display("FAIL wrap_bresp: got %h required %h", got_bresp, exp);
        end
        do_ar(4'h8, 32'hFFFF_FFFC, 1, 2'b01, 3'b010);
        do_r(1, -1, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd_q[i] !== exp_rdata(32'hFFFF_FFFC, i, 2'b01) || rr_q[i] !== exp_rresp(32'hFFFF_FFFC, i, 2'b01, 3'b010)) begin
                errors++;
                $display("FAIL wrap_rd%0d: got data=%h resp=%h required data=%h resp=%h", i, rd_q[i], rr_q[i],
                         exp_rdata(32'hFFFF_FFFC, i, 2'b01), exp_rresp(32'hFFFF_FFFC, i, 2'b01, 3'b010));
            end
        end
    endtask

    task automatic test_reset_midburst;
        int n;
        do_ar(4'h2, 32'h100, 3, 2'b01, 3'b010);
        wait_sig(4, "r_rst", n);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        wait_sig(4, "r_rst", n);
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0 || awready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got rvalid=%b rlast=%b rdata=%h awready=%b required 0 0 0 0",
                     rvalid, rlast, rdata, awready);
        end
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: got awready=%b rvalid=%b required 1 0", awready, rvalid);
        end
        do_ar(4'hC, 32'h100, 3, 2'b01, 3'b010);
        do_r(3, -1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q[i] !== exp_rdata(32'h100, i, 2'b01) || rl_q[i] !== (i == 3) || got_rid !== 4'hC) begin
                errors++;
                $display("FAIL rst_rd%0d: got data=%h last=%b rid=%h required data=%h last=%b rid=c",
                         i, rd_q[i], rl_q[i], got_rid, exp_rdata(32'h100, i, 2'b01), (i == 3));
            end
        end
    endtask

    task automatic test_random;
        int len, wl;
        logic [1:0] burst, exp;
        logic [2:0] size;
        logic [3:0] id;
        logic [31:0] base;
        for (int n = 0; n < 16; n++) begin
            len = $urandom_range(0, 7);
            burst = 2'($urandom_range(0, 3));
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            id = 4'($urandom);
            if ($urandom_range(0, 2) == 0) base = 32'h0001_0000 - 32'(4 * $urandom_range(1, 6));
            else base = 32'(4 * $urandom_range(256, 16383));
            base = base | 32'($urandom_range(0, 3));
            for (int i = 0; i <= len; i++) begin
                wq[i] = $urandom;
                sq[i] = 4'hF;
            end
            exp = model_write(base, len, burst, size, len);
            do_aw(id, base, len, burst, size);
            do_w(len, len);
            do_b(0);
            for (int i = 0; i <= len; i++) begin
                wq[i] = $urandom;
                sq[i] = 4'($urandom);
            end
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : len;
            exp = model_write(base, len, burst, size, wl);
            do_aw(id, base, len, burst, size);
            do_w(len, wl);
            do_b(int'($urandom_range(0, 2)));
            checks++;
            if (got_bresp !== exp || got_bid !== id) begin
                errors++;
                $display("FAIL rnd%0d_b: got resp=%h id=%h required resp=%h id=%h", n, got_bresp, got_bid, exp, id);
            end
            do_ar(~id, base, len, burst, size);
            do_r(len, int'($urandom_range(0, len)), int'($urandom_range(0, 2)));
            for (int i = 0; i <= len; i++) begin
                checks++;
                if (rd_q[i] !== exp_rdata(base, i, burst) || rr_q[i] !== exp_rresp(base, i, burst, size)
                    || rl_q[i] !== (i == len)) begin
                    errors++;
                    $display("FAIL rnd%0d_r%0d: got data=%h resp=%h last=%b required data=%h resp=%h last=%b",
                             n, i, rd_q[i], rr_q[i], rl_q[i], exp_rdata(base, i, burst),
                             exp_rresp(base, i, burst, size), (i == len));
                end
            end
            checks++;
            if (got_rid !== ~id || stall_ok !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_rid: got rid=%h stable=%b required rid=%h stable=1", n, got_rid, stall_ok, ~id);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        awid = 4'h0; awaddr = 32'h0; awlen = 8'h0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
        wid = 4'h0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 4'h0; araddr = 32'h0; arlen = 8'h0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        stall_ok = 1'b1; r_extra = 1'b0; got_lat = 0; t_ar = 0; t_b = 0;
        got_bresp = 2'b00; got_bid = 4'h0; got_rid = 4'h0;
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_backpressure();
        test_simultaneous();
        test_errors();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
